wide_uart_rx: RTL
=================

# wide_uart_rx

Receive half of the board-side UART link. Deserialises 8N1 frames arriving on `RsRx`, packs eight consecutive bytes into one 64-bit word, and presents it on an AXI-Stream master toward the processing core. Its 64-bit input comes from the host's wide UART transmitter. Framing errors, inter-byte timeouts and output overruns are detected and flagged, and corrupted words are never forwarded.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer divide, 868 at defaults).
- `TIMEOUT_BITS`, 32: idle bit-periods after which a partial word is discarded.

- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RsRx`  in  1  serial line, idle high, asynchronous to `clk`.
- `m_axis_tdata`  out  64  assembled word.
- `m_axis_tvalid`  out  1  word available.
- `m_axis_tready`  in  1  consumer accepts.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: word completed while previous still held.
- `timeout`  out  1  one-cycle pulse: partial word discarded on idle.

## Operation
- `RsRx` passes through a 2-flop synchroniser. Both flops reset to 1.
- Bit receiver FSM:
  - IDLE: wait for synchronised line = 0, then go to START and clear the counter.
  - START: at count `CLKS_PER_BIT/2`, resample. If the line is 1, treat it as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first, 8 bits.
  - STOP: sample after one more `CLKS_PER_BIT`. If 1, emit the byte. If 0, pulse `frame_err`, drop the byte and clear the packer. Return to IDLE in both cases.
- Packer:
  - The first byte of a word lands in [63:56] and the eighth in [7:0]. Host word 64'hfeedfacedeadbeef is therefore sent as fe, ed, fa, ce, de, ad, be, ef.
  - A 3-bit byte index counts 0..7 and wraps to 0 on word completion.
- Output register:
  - When the 8th byte arrives and `m_axis_tvalid` is 0, or the held word is accepted that same cycle, load the word and set `tvalid`.
  - Otherwise drop the new word, keep the held word, and pulse `overrun`.
- Timeout:
  - The idle counter runs while the FSM is in IDLE with byte index ≠ 0, and clears on any start-bit detection.
  - At `TIMEOUT_BITS*CLKS_PER_BIT` cycles, reset the byte index to 0 and pulse `timeout`.
  - No timeout is raised when the index is 0.

## Timing
- Reset values:
  - `m_axis_tdata` = 0, `m_axis_tvalid` = 0, all pulses 0.
  - FSM = IDLE, byte index = 0, counters = 0.
  - Reset mid-frame or mid-word discards everything.
- Start detection occurs 2 cycles after the `RsRx` falling edge.
- The stop bit is sampled `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after detection.
- For the 8th byte, `m_axis_tvalid` rises on the cycle after the stop sample.
- `frame_err`, `timeout` and `overrun` are asserted on the cycle after their triggering sample or count.
- AXIS handshake:
  - Transfer occurs on `tvalid && tready`. `tdata` is stable while `tvalid=1 && !tready`.
  - `tvalid` does not depend combinationally on `tready`.
  - After acceptance, `tvalid` drops the next cycle unless a new word loads on that same edge.
- A stop bit that completes a word while `tready=1` and the held word is being accepted is not an overrun. The new word loads and `tvalid` stays 1.

## Structure
- Package `wide_uart_pkg` contains:
  - `rx_state_t` enum {IDLE, START, DATA, STOP};
  - `BYTES_PER_WORD = 8` and the `WORD_W = 64` constant;
  - a function `clks_per_bit(freq, baud)`.
- Sub-module `uart_rx_byte` holds the synchroniser, bit FSM and baud counter. It outputs `byte_data[7:0]`, `byte_valid` (1-cycle pulse) and `frame_err`.
- The top level holds the packer, timeout counter and output register.
- The bench uses `CLKS_PER_BIT = 16` (`CLK_FREQ = 16*BAUD`) for short sims.

## Test plan
- Send fe,ed,fa,ce,de,ad,be,ef with `tready=1`. Expect one transfer, `m_axis_tdata` = 64'hfeedfacedeadbeef, no flags.
- Send a 0.25-bit low glitch on `RsRx`, then a normal word 64'h0123456789abcdef. Expect no byte from the glitch and the word received intact.
- Send the third byte with its stop bit low. Expect a `frame_err` pulse and index reset. The following 8 bytes 11..88 yield 64'h1122334455667788.
- Send 3 bytes, then idle for 33 bit-periods. Expect a `timeout` pulse. The next 8 bytes a0..a7 yield 64'ha0a1a2a3a4a5a6a7.
- Hold `tready=0` and send two full words, W1 then W2. Expect an `overrun` pulse at W2 completion. After `tready=1`, exactly W1 is delivered and W2 is lost.
- Assert `rst_n=0` mid-byte of word 2, release, then send 8 bytes. Expect `tvalid=0` during reset and only the new word delivered.

Source files
------------

// File: rtl/wide_uart_pkg.sv
// Shared types and constants for the wide UART receive path.
// Line state machine encoding, word geometry and baud divisor helper.
package wide_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int BYTES_PER_WORD = 8;
    localparam int WORD_W         = 64;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, start/data/stop FSM, baud counter.
// Byte or frame error pulses one cycle after the stop sample; no backpressure.
module uart_rx_byte
    import wide_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       line_idle,
    output logic       start_det
);

    localparam int                CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  HALF_C = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = START;
                end
            end
            START: begin
                // A line that is high again at mid-bit was a glitch, not a start bit.
                if (cnt_q == HALF_C) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync2_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign line_idle  = (state_q == IDLE);
    assign start_det  = (state_q == IDLE) && !sync2_q;

endmodule

// File: rtl/wide_uart_rx.sv
// UART receive path packing 8 bytes (first byte in the MSBs) into one AXI-Stream word.
// Word valid one cycle after the last byte strobe; a word completing while one is held is dropped.
module wide_uart_rx
    import wide_uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RsRx,
    output logic [WORD_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              frame_err,
    output logic              overrun,
    output logic              timeout
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int               TMO_CYCLES   = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int               TMO_W        = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TMO_CYCLES - 1);
    localparam int               IDX_W        = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(BYTES_PER_WORD - 1);

    logic [7:0] rx_byte;
    logic       rx_byte_vld;
    logic       rx_frame_err;
    logic       rx_line_idle;
    logic       rx_start_det;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (RsRx),
        .byte_data (rx_byte),
        .byte_valid(rx_byte_vld),
        .frame_err (rx_frame_err),
        .line_idle (rx_line_idle),
        .start_det (rx_start_det)
    );

    // Only the first seven bytes need holding; the eighth joins straight from the receiver.
    logic [WORD_W-9:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WORD_W-1:0]  tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;

    always_comb begin
        word_d     = word_q;
        idx_d      = idx_q;
        idle_cnt_d = idle_cnt_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (rx_frame_err) begin
            idx_d = '0;
        end else if (rx_byte_vld) begin
            word_d = {word_q[WORD_W-17:0], rx_byte};
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                // A word accepted on this same edge frees the slot for the new one.
                if (!tvalid_q || m_axis_tready) begin
                    tdata_d  = {word_q, rx_byte};
                    tvalid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (rx_line_idle && (idx_q != '0) && !rx_start_det) begin
            if (idle_cnt_q == TMO_LAST) begin
                idle_cnt_d = '0;
                idx_d      = '0;
                timeout_d  = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            idx_q      <= '0;
            idle_cnt_q <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            word_q     <= word_d;
            idx_q      <= idx_d;
            idle_cnt_q <= idle_cnt_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = rx_frame_err;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;

endmodule
